// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core fetch port, loaded by the host over a valid/ready stream; holds the core in reset while loading.
// Optional INST_ROM_CHECKSUM_EN adds ld_sum_o, the running sum of the words written by the current load.
module inst_rom_loader #(
   parameter int DEPTH_LOG2 = 10,
   parameter bit BOOT_RUN   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_ce_i,
   input  logic [31:0]           rom_addr_i,
   output logic [31:0]           rom_data_o,
   input  logic                  ld_start_i,
   input  logic                  ld_valid_i,
   output logic                  ld_ready_o,
   input  logic [31:0]           ld_data_i,
   input  logic                  ld_last_i,
   output logic                  cpu_rst_o,
   output logic [DEPTH_LOG2:0]   ld_cnt_o,
   output logic                  ovf_o
`ifdef INST_ROM_CHECKSUM_EN
   ,
   output logic [31:0]           ld_sum_o
`endif
);

   // state  | meaning
   // S_IDLE | no image yet, core held in reset, waiting for ld_start_i
   // S_LOAD | accepting image beats, core held in reset
   // S_RUN  | image complete, core released; ld_start_i reloads
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   localparam int     CW        = DEPTH_LOG2 + 1;
   localparam int     DEPTH     = 1 << DEPTH_LOG2;
   localparam state_t RST_STATE = BOOT_RUN ? S_RUN : S_IDLE;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            cpu_rst_q;
   logic            full;
   logic            wr_en;
   logic [31:0]     mem [DEPTH];

`ifdef INST_ROM_CHECKSUM_EN
   logic [31:0]     sum_q, sum_d;
`endif

   // cnt_q doubles as the write pointer; its top bit set means the array is full.
   assign full  = cnt_q[DEPTH_LOG2];
   assign wr_en = (state_q == S_LOAD) && ld_valid_i && !full;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      ld_ready_o = 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      case (state_q)
         S_LOAD: begin
            ld_ready_o = 1'b1;
            if (ld_valid_i) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
`ifdef INST_ROM_CHECKSUM_EN
                  sum_d = sum_q + ld_data_i;
`endif
               end
               if (ld_last_i) state_d = S_RUN;
            end
         end
         default: begin
            if (ld_start_i) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               ovf_d   = 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RST_STATE;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         cpu_rst_q <= (state_d != S_RUN);
      end
   end

`ifdef INST_ROM_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sum_q <= '0;
      else     sum_q <= sum_d;
   end
   assign ld_sum_o = sum_q;
`endif

   // Array is deliberately not reset so a reset mid-load keeps the words already written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[cnt_q[DEPTH_LOG2-1:0]] <= ld_data_i;
   end

   assign rom_data_o = rom_ce_i ? mem[rom_addr_i[DEPTH_LOG2+1:2]] : 32'h0;
   assign cpu_rst_o  = cpu_rst_q;
   assign ld_cnt_o   = cnt_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader (default DEPTH_LOG2=10, BOOT_RUN=0).
module tb_inst_rom_loader;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rom_ce_i = 1'b0;
   logic [31:0]  rom_addr_i = '0;
   logic [31:0]  rom_data_o;
   logic         ld_start_i = 1'b0;
   logic         ld_valid_i = 1'b0;
   logic         ld_ready_o;
   logic [31:0]  ld_data_i = '0;
   logic         ld_last_i = 1'b0;
   logic         cpu_rst_o;
   logic [10:0]  ld_cnt_o;
   logic         ovf_o;
`ifdef INST_ROM_CHECKSUM_EN
   logic [31:0]  ld_sum_o;
`endif

   int checks = 0;
   int failures = 0;
   int rdy_cycles;

   inst_rom_loader #(.DEPTH_LOG2(10), .BOOT_RUN(1'b0)) dut (
      .clk(clk), .rst(rst),
      .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
      .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
      .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
      .cpu_rst_o(cpu_rst_o), .ld_cnt_o(ld_cnt_o), .ovf_o(ovf_o)
`ifdef INST_ROM_CHECKSUM_EN
      , .ld_sum_o(ld_sum_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input string tag, input logic ce, input logic [31:0] addr, input logic [31:0] exp);
      rom_ce_i   = ce;
      rom_addr_i = addr;
      #1;
      chk(tag, rom_data_o, exp);
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      chk("rst_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
      chk("rst_ready",   {31'b0, ld_ready_o}, 32'd0);
      chk("rst_cnt",     {21'b0, ld_cnt_o}, 32'd0);
      chk("rst_ovf",     {31'b0, ovf_o}, 32'd0);
`ifdef INST_ROM_CHECKSUM_EN
      chk("rst_sum",     ld_sum_o, 32'd0);
`endif
      rst = 1'b0;
      tick();
      chk("idle_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);

      // three-word image
      ld_start_i = 1'b1;
      tick();
      ld_start_i = 1'b0;
      rdy_cycles = 0;
      ld_valid_i = 1'b1;
      ld_data_i = 32'h34010001; ld_last_i = 1'b0; #1; rdy_cycles += int'(ld_ready_o); tick();
      chk("load_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
      ld_data_i = 32'h34020002; #1; rdy_cycles += int'(ld_ready_o); tick();
      ld_data_i = 32'h00221820; ld_last_i = 1'b1; #1; rdy_cycles += int'(ld_ready_o); tick();
      ld_valid_i = 1'b0; ld_last_i = 1'b0;
      rdy_cycles += int'(ld_ready_o);
      chk("img3_ready_cycles", rdy_cycles, 32'd3);
      chk("img3_cnt",     {21'b0, ld_cnt_o}, 32'd3);
      chk("img3_cpu_rst", {31'b0, cpu_rst_o}, 32'd0);
      chk("img3_ovf",     {31'b0, ovf_o}, 32'd0);
      fetch("fetch_addr8",   1'b1, 32'h8,    32'h00221820);
      fetch("fetch_ce0",     1'b0, 32'h4,    32'h0);
      fetch("fetch_alias",   1'b1, 32'h1004, 32'h34020002);
      fetch("fetch_byteoff", 1'b1, 32'h3,    32'h34010001);
      tick();
      chk("run_hold_cnt", {21'b0, ld_cnt_o}, 32'd3);

      // overflow: DEPTH+2 beats
      ld_start_i = 1'b1;
      tick();
      ld_start_i = 1'b0;
      chk("ovf_start_cnt", {21'b0, ld_cnt_o}, 32'd0);
      ld_valid_i = 1'b1;
      for (int i = 0; i < 1026; i++) begin
         if (i == 1024) begin
            chk("full_cnt", {21'b0, ld_cnt_o}, 32'd1024);
            chk("full_ovf_clear", {31'b0, ovf_o}, 32'd0);
         end
         ld_data_i = 32'hA0000000 + i;
         ld_last_i = (i == 1025);
         tick();
      end
      ld_valid_i = 1'b0; ld_last_i = 1'b0;
      chk("ovf_cnt",     {21'b0, ld_cnt_o}, 32'd1024);
      chk("ovf_flag",    {31'b0, ovf_o}, 32'd1);
      chk("ovf_cpu_rst", {31'b0, cpu_rst_o}, 32'd0);
      chk("ovf_ready",   {31'b0, ld_ready_o}, 32'd0);
      fetch("ovf_mem0",    1'b1, 32'h0,   32'hA0000000);
      fetch("ovf_mem1",    1'b1, 32'h4,   32'hA0000001);
      fetch("ovf_memlast", 1'b1, 32'hFFC, 32'hA00003FF);

      // start with valid in RUN: start wins, no beat
      ld_start_i = 1'b1; ld_valid_i = 1'b1; ld_data_i = 32'hDEADBEEF;
      tick();
      ld_start_i = 1'b0; ld_valid_i = 1'b0;
      chk("restart_ready",   {31'b0, ld_ready_o}, 32'd1);
      chk("restart_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
      chk("restart_cnt",     {21'b0, ld_cnt_o}, 32'd0);
      chk("restart_ovf",     {31'b0, ovf_o}, 32'd0);
      fetch("restart_mem0", 1'b1, 32'h0, 32'hA0000000);

      // read-during-write returns the old word, then reset after two beats
      ld_valid_i = 1'b1; ld_data_i = 32'h11111111;
      fetch("rdw_old", 1'b1, 32'h0, 32'hA0000000);
      tick();
      chk("rdw_new", rom_data_o, 32'h11111111);
      ld_data_i = 32'h22222222;
      tick();
      ld_valid_i = 1'b0;
      chk("mid_cnt", {21'b0, ld_cnt_o}, 32'd2);
      rst = 1'b1;
      #1;
      chk("abort_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
      chk("abort_cnt",     {21'b0, ld_cnt_o}, 32'd0);
      chk("abort_ready",   {31'b0, ld_ready_o}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("abort_idle_ready", {31'b0, ld_ready_o}, 32'd0);
      fetch("abort_mem0", 1'b1, 32'h0, 32'h11111111);
      fetch("abort_mem1", 1'b1, 32'h4, 32'h22222222);
      fetch("abort_mem2", 1'b1, 32'h8, 32'hA0000002);

`ifdef INST_ROM_CHECKSUM_EN
      ld_start_i = 1'b1;
      tick();
      ld_start_i = 1'b0;
      ld_valid_i = 1'b1; ld_data_i = 32'hFFFFFFFF;
      tick();
      ld_data_i = 32'h00000002; ld_last_i = 1'b1;
      tick();
      ld_valid_i = 1'b0; ld_last_i = 1'b0;
      chk("sum_wrap", ld_sum_o, 32'h00000001);
      tick();
      chk("sum_hold", ld_sum_o, 32'h00000001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
